// File: rtl/perf_pkg.sv
// Shared types for the performance counter bank: event indices, read-source select
// and counter word.
package perf_pkg;

  typedef enum logic [4:0] {
    EV_CYCLE    = 5'd0,
    EV_STALL    = 5'd1,
    EV_BUBBLE   = 5'd2,
    EV_L1I_HIT  = 5'd3,
    EV_L1I_MISS = 5'd4,
    EV_L1D_HIT  = 5'd5,
    EV_L1D_MISS = 5'd6,
    EV_L2_HIT   = 5'd7,
    EV_L2_MISS  = 5'd8,
    EV_BR       = 5'd9,
    EV_BR_CORR  = 5'd10,
    EV_BTB_MISS = 5'd11
  } perf_ev_e;

  localparam int unsigned NUM_EV = 12;

  typedef enum logic {
    RdSrcLive = 1'b0,
    RdSrcSnap = 1'b1
  } rd_src_e;

  localparam int unsigned MAX_CNT_W = 64;

  // Widest supported counter; narrower banks use the low CNT_W bits.
  typedef logic [MAX_CNT_W-1:0] cnt_word_t;

endpackage

// File: rtl/perf_counter_bank_if.sv
// Read port of the counter bank: request/select/source in, registered response out.
interface perf_counter_bank_if #(
  parameter int unsigned SEL_W = 5,
  parameter int unsigned CNT_W = 32
);
  import perf_pkg::*;

  logic             rd_req;
  logic [SEL_W-1:0] rd_sel;
  rd_src_e          rd_src;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic             rd_err;

  modport master (
    output rd_req, rd_sel, rd_src,
    input  rd_valid, rd_data, rd_err
  );

  modport slave (
    input  rd_req, rd_sel, rd_src,
    output rd_valid, rd_data, rd_err
  );

endinterface

// File: rtl/perf_counter_cell.sv
// One counter channel: increment adder with wrap/saturate, sticky overflow, clear and
// snapshot register.
module perf_counter_cell #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned INC_W    = 2,
  parameter int unsigned SAT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INC_W-1:0] inc_i,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] snap_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] upd;
  logic             carry;

  always_comb begin
    sum   = {1'b0, cnt_q} + (CNT_W + 1)'(inc_i);
    carry = en_i & sum[CNT_W];
    if (!en_i) begin
      upd = cnt_q;
    end else if (carry && (SAT_MODE != 0)) begin
      upd = '1;
    end else begin
      upd = sum[CNT_W-1:0];
    end

    cnt_d = upd;
    ovf_d = ovf_q | carry;
    if (clear_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end

    // Snapshot sees the post-increment value even when a clear lands in the same cycle.
    snap_d = snap_i ? upd : snap_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      snap_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign snap_o = snap_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Parametrised bank of event counters with snapshot bank and a registered read port.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NUM_CNT  = 24,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned INC_W    = 2,
  parameter int unsigned SAT_MODE = 0,
  parameter int unsigned SEL_W    = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CNT*INC_W-1:0] inc_i,
  input  logic                     en_i,
  input  logic                     clear_i,
  input  logic                     snap_i,
  perf_counter_bank_if.slave       rd_if,
  output logic [NUM_CNT-1:0]       ovf_o,
  output logic                     snap_valid_o
);

  logic [CNT_W-1:0] cnt_arr  [NUM_CNT];
  logic [CNT_W-1:0] snap_arr [NUM_CNT];

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cell
    perf_counter_cell #(
      .CNT_W    (CNT_W),
      .INC_W    (INC_W),
      .SAT_MODE (SAT_MODE)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (inc_i[k*INC_W +: INC_W]),
      .en_i    (en_i),
      .clear_i (clear_i),
      .snap_i  (snap_i),
      .cnt_o   (cnt_arr[k]),
      .snap_o  (snap_arr[k]),
      .ovf_o   (ovf_o[k])
    );
  end

  logic             snap_valid_q, snap_valid_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_err_q, rd_err_d;

  always_comb begin
    snap_valid_d = snap_valid_q | snap_i;
    rd_valid_d   = rd_if.rd_req;
    rd_data_d    = rd_data_q;
    rd_err_d     = 1'b0;
    if (rd_if.rd_req) begin
      if (int'(rd_if.rd_sel) >= int'(NUM_CNT)) begin
        rd_data_d = '0;
        rd_err_d  = 1'b1;
      end else if (rd_if.rd_src == RdSrcSnap) begin
        rd_data_d = snap_arr[rd_if.rd_sel];
      end else begin
        rd_data_d = cnt_arr[rd_if.rd_sel];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_err_q     <= 1'b0;
    end else begin
      snap_valid_q <= snap_valid_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_err_q     <= rd_err_d;
    end
  end

  assign snap_valid_o   = snap_valid_q;
  assign rd_if.rd_valid = rd_valid_q;
  assign rd_if.rd_data  = rd_data_q;
  assign rd_if.rd_err   = rd_err_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench: a 24x32 wrap bank plus two 4x8 banks (wrap / saturate) on shared controls.
module tb_perf_counter_bank;
  import perf_pkg::*;

  logic        clk;
  logic        rst;
  logic [47:0] inc_m;
  logic [7:0]  inc_w;
  logic        en, clear, snap;
  logic [23:0] ovf_m;
  logic [3:0]  ovf_w, ovf_s;
  logic        sv_m, sv_w, sv_s;

  perf_counter_bank_if #(.SEL_W(5), .CNT_W(32)) m_if ();
  perf_counter_bank_if #(.SEL_W(2), .CNT_W(8))  w_if ();
  perf_counter_bank_if #(.SEL_W(2), .CNT_W(8))  s_if ();

  perf_counter_bank #(.NUM_CNT(24), .CNT_W(32), .INC_W(2), .SAT_MODE(0)) dut_m (
    .clk(clk), .rst(rst), .inc_i(inc_m), .en_i(en), .clear_i(clear), .snap_i(snap),
    .rd_if(m_if), .ovf_o(ovf_m), .snap_valid_o(sv_m)
  );
  perf_counter_bank #(.NUM_CNT(4), .CNT_W(8), .INC_W(2), .SAT_MODE(0)) dut_w (
    .clk(clk), .rst(rst), .inc_i(inc_w), .en_i(en), .clear_i(clear), .snap_i(snap),
    .rd_if(w_if), .ovf_o(ovf_w), .snap_valid_o(sv_w)
  );
  perf_counter_bank #(.NUM_CNT(4), .CNT_W(8), .INC_W(2), .SAT_MODE(1)) dut_s (
    .clk(clk), .rst(rst), .inc_i(inc_w), .en_i(en), .clear_i(clear), .snap_i(snap),
    .rd_if(s_if), .ovf_o(ovf_s), .snap_valid_o(sv_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a read request on one bank and queue the response it must produce next cycle.
  task automatic issue(input int id, input int sel, input logic src, input logic [31:0] data,
                       input logic err);
    rsp_t e;
    case (id)
      0: begin m_if.rd_req = 1'b1; m_if.rd_sel = 5'(sel); m_if.rd_src = rd_src_e'(src); end
      1: begin w_if.rd_req = 1'b1; w_if.rd_sel = 2'(sel); w_if.rd_src = rd_src_e'(src); end
      default: begin
        s_if.rd_req = 1'b1; s_if.rd_sel = 2'(sel); s_if.rd_src = rd_src_e'(src);
      end
    endcase
    e.id   = id;
    e.data = data;
    e.err  = err;
    sb_q.push_back(e);
  endtask

  task automatic check_rsp();
    rsp_t e;
    int   n;
    n = sb_q.size();
    for (int i = 0; i < n; i++) begin
      e = sb_q.pop_front();
      case (e.id)
        0: begin
          chk($sformatf("m_valid_%0d", n_cmp), 64'(m_if.rd_valid), 64'd1);
          chk($sformatf("m_data_%0d", n_cmp), 64'(m_if.rd_data), 64'(e.data));
          chk($sformatf("m_err_%0d", n_cmp), 64'(m_if.rd_err), 64'(e.err));
        end
        1: begin
          chk($sformatf("w_valid_%0d", n_cmp), 64'(w_if.rd_valid), 64'd1);
          chk($sformatf("w_data_%0d", n_cmp), 64'(w_if.rd_data), 64'(e.data));
        end
        default: begin
          chk($sformatf("s_valid_%0d", n_cmp), 64'(s_if.rd_valid), 64'd1);
          chk($sformatf("s_data_%0d", n_cmp), 64'(s_if.rd_data), 64'(e.data));
        end
      endcase
    end
  endtask

  task automatic idle_reads();
    m_if.rd_req = 1'b0;
    w_if.rd_req = 1'b0;
    s_if.rd_req = 1'b0;
  endtask

  task automatic rd_cycle();
    idle_reads();
    step();
    check_rsp();
  endtask

  // Requests are cleared before the clock, so issue() must precede each rd_cycle only via
  // rd_step, which keeps the request asserted across the edge.
  task automatic rd_step();
    step();
    check_rsp();
    idle_reads();
  endtask

  task automatic rd_done();
    idle_reads();
    step();
    chk("m_valid_idle", 64'(m_if.rd_valid), 64'd0);
    chk("w_valid_idle", 64'(w_if.rd_valid), 64'd0);
    chk("s_valid_idle", 64'(s_if.rd_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; inc_m = '0; inc_w = '0; en = 1'b0; clear = 1'b0; snap = 1'b0;
    m_if.rd_req = 1'b0; m_if.rd_sel = '0; m_if.rd_src = RdSrcLive;
    w_if.rd_req = 1'b0; w_if.rd_sel = '0; w_if.rd_src = RdSrcLive;
    s_if.rd_req = 1'b0; s_if.rd_sel = '0; s_if.rd_src = RdSrcLive;
    #2 rst = 1'b0;
    #10;
    chk("rst_valid", 64'(m_if.rd_valid), 64'd0);
    chk("rst_data", 64'(m_if.rd_data), 64'd0);
    chk("rst_err", 64'(m_if.rd_err), 64'd0);
    chk("rst_ovf", 64'(ovf_m), 64'd0);
    chk("rst_snapv", 64'(sv_m), 64'd0);
    step();
    rst = 1'b1;

    // Ch0 counts 1 per cycle for 10 cycles.
    en = 1'b1; inc_m = 48'h1;
    for (int i = 0; i < 10; i++) step();
    inc_m = '0;
    issue(0, 0, 1'b0, 32'd10, 1'b0);
    rd_step();
    rd_done();

    // 8-bit banks: ch3 to 254, ch2 to exactly 255 (no overflow).
    for (int i = 0; i < 127; i++) begin
      inc_w = {2'd2, (i < 85) ? 2'd3 : 2'd0, 4'd0};
      step();
    end
    chk("w_ovf2_exact", 64'(ovf_w[2]), 64'd0);
    chk("s_ovf2_exact", 64'(ovf_s[2]), 64'd0);
    chk("w_ovf3_pre", 64'(ovf_w[3]), 64'd0);
    inc_w = {2'd3, 6'd0};
    step();
    chk("w_ovf3", 64'(ovf_w[3]), 64'd1);
    chk("s_ovf3", 64'(ovf_s[3]), 64'd1);
    inc_w = {2'd1, 6'd0};
    issue(1, 3, 1'b0, 32'd1, 1'b0);
    issue(2, 3, 1'b0, 32'd255, 1'b0);
    rd_step();
    inc_w = '0;
    issue(1, 3, 1'b0, 32'd2, 1'b0);
    issue(2, 3, 1'b0, 32'd255, 1'b0);
    rd_step();
    issue(1, 2, 1'b0, 32'd255, 1'b0);
    issue(2, 2, 1'b0, 32'd255, 1'b0);
    rd_step();
    rd_done();

    // Freeze with en=0, then clear overriding active increments.
    inc_m = 48'h10;
    for (int i = 0; i < 7; i++) step();
    en = 1'b0; inc_m = '1; inc_w = '1;
    for (int i = 0; i < 5; i++) step();
    issue(0, 2, 1'b0, 32'd7, 1'b0);
    issue(1, 3, 1'b0, 32'd2, 1'b0);
    issue(2, 3, 1'b0, 32'd255, 1'b0);
    rd_step();
    issue(0, 0, 1'b0, 32'd10, 1'b0);
    rd_step();
    rd_done();
    chk("w_ovf_frozen", 64'(ovf_w), 64'h8);
    en = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0; inc_m = '0; inc_w = '0;
    chk("m_ovf_clr", 64'(ovf_m), 64'd0);
    chk("w_ovf_clr", 64'(ovf_w), 64'd0);
    chk("s_ovf_clr", 64'(ovf_s), 64'd0);
    issue(0, 2, 1'b0, 32'd0, 1'b0);
    issue(1, 3, 1'b0, 32'd0, 1'b0);
    issue(2, 3, 1'b0, 32'd0, 1'b0);
    rd_step();
    issue(0, 0, 1'b0, 32'd0, 1'b0);
    rd_step();
    rd_done();

    // Atomic snapshot + clear: ch0 50->51, ch1 100->102.
    inc_m = 48'h9;
    for (int i = 0; i < 50; i++) step();
    snap = 1'b1; clear = 1'b1;
    step();
    snap = 1'b0; clear = 1'b0; inc_m = '0;
    chk("m_snapv", 64'(sv_m), 64'd1);
    chk("s_snapv", 64'(sv_s), 64'd1);
    issue(0, 1, 1'b1, 32'd102, 1'b0);
    rd_step();
    issue(0, 1, 1'b0, 32'd0, 1'b0);
    rd_step();
    issue(0, 0, 1'b1, 32'd51, 1'b0);
    rd_step();
    issue(0, 0, 1'b0, 32'd0, 1'b0);
    rd_step();
    rd_done();

    // Out-of-range select and held back-to-back reads.
    issue(0, 30, 1'b0, 32'd0, 1'b1);
    rd_step();
    rd_done();
    inc_m = 48'h31;
    for (int i = 0; i < 4; i++) step();
    inc_m = '0;
    issue(0, 0, 1'b0, 32'd4, 1'b0);
    rd_step();
    issue(0, 1, 1'b0, 32'd0, 1'b0);
    rd_step();
    issue(0, 24, 1'b0, 32'd0, 1'b1);
    rd_step();
    issue(0, 23, 1'b0, 32'd0, 1'b0);
    rd_step();
    issue(0, 2, 1'b0, 32'd12, 1'b0);
    rd_step();
    rd_done();
    chk("m_data_hold", 64'(m_if.rd_data), 64'd12);
    chk("m_snapv_sticky", 64'(sv_m), 64'd1);

    // Reset with a read response on the outputs.
    inc_m = 48'h1;
    for (int i = 0; i < 3; i++) step();
    inc_m = '0;
    issue(0, 0, 1'b0, 32'd7, 1'b0);
    rd_step();
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(m_if.rd_valid), 64'd0);
    chk("arst_data", 64'(m_if.rd_data), 64'd0);
    chk("arst_err", 64'(m_if.rd_err), 64'd0);
    chk("arst_snapv", 64'(sv_m), 64'd0);
    chk("arst_ovf_w", 64'(ovf_w), 64'd0);
    inc_m = 48'h1;
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    inc_m = '0;
    issue(0, 0, 1'b0, 32'd5, 1'b0);
    rd_step();
    issue(0, 1, 1'b1, 32'd0, 1'b0);
    rd_step();
    rd_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Synthesizable, parametrised bank of event counters that replaces ad-hoc testbench tallies (cache hit/miss, stall/bubble, branch-predictor events).
- Sits beside the CPU top; each channel is driven by a per-cycle increment field from the pipeline, caches or branch predictor.
- Adds saturate/wrap modes, sticky overflow, atomic snapshot for interval sampling, and a registered read port for the debug/host side.

Parameters:
- NUM_CNT, 24, number of counter channels (>=1).
- CNT_W, 32, counter width in bits (8..64).
- INC_W, 2, increment field width per channel; max increment per cycle is 2^INC_W-1.
- SAT_MODE, 0, 0 = wrap on overflow, 1 = saturate at all-ones.
- SEL_W, $clog2(NUM_CNT) (minimum 1), read-select width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- inc_i  in  NUM_CNT*INC_W  per-channel increment amount; channel k uses bits [k*INC_W +: INC_W].
- en_i  in  1  global count enable; 0 freezes all live counters.
- clear_i  in  1  synchronous clear of all live counters and overflow flags.
- snap_i  in  1  capture all channels into the snapshot bank.
- rd_req_i  in  1  read request, one-cycle pulse or held.
- rd_sel_i  in  SEL_W  channel index to read.
- rd_src_i  in  1  0 = live counter, 1 = snapshot.
- rd_valid_o  out  1  read data valid.
- rd_data_o  out  CNT_W  read data.
- rd_err_o  out  1  set with rd_valid_o when rd_sel_i >= NUM_CNT.
- ovf_o  out  NUM_CNT  sticky overflow/saturation flag per channel.
- snap_valid_o  out  1  snapshot bank holds a capture.

Behaviour:
- Reset (rst=0, asynchronous): all live counters, snapshots, ovf_o, rd_valid_o, rd_data_o, rd_err_o and snap_valid_o go to 0.
- Next value per channel k: nxt = cnt + inc when en_i=1, otherwise cnt.
  - The adder is CNT_W+1 bits wide; carry out indicates overflow.
- Overflow handling:
  - SAT_MODE=0: cnt <= nxt[CNT_W-1:0] and ovf[k] <= 1.
  - SAT_MODE=1: cnt <= all-ones and ovf[k] <= 1.
  - Exactly reaching all-ones is not an overflow.
- In saturate mode a channel already at all-ones stays there. ovf[k] is set when the carry first occurs.
- clear_i=1: cnt <= 0 and ovf <= 0 on all channels. This overrides any increment in the same cycle.
- snap_i=1:
  - snap[k] <= nxt after the wrap/saturate rule, including that cycle's increment but ignoring a same-cycle clear_i.
  - snap_valid_o <= 1.
  - snap_i and clear_i together therefore give an atomic read-and-reset interval sample.
- snap_valid_o clears only on reset. Later snap_i pulses overwrite the snapshot bank.
- Read port:
  - rd_req_i in cycle N produces rd_valid_o=1 in cycle N+1, with rd_data_o = live or snapshot value of the selected channel as registered at the end of cycle N.
  - For live reads this is the value before cycle N's update.
  - One result per requesting cycle; a held rd_req_i gives back-to-back reads at full throughput.
- When rd_req_i=0, rd_valid_o=0 next cycle. rd_data_o holds its last value.
- rd_sel_i >= NUM_CNT: rd_data_o=0 and rd_err_o=1 for that response. Otherwise rd_err_o=0.
- No back-pressure on the read port; the consumer must accept every rd_valid_o.
- Reset mid-operation: all state clears immediately, and an in-flight read response is dropped (rd_valid_o=0).
- Live counters can be updated, snapshotted and read in the same cycle. The read returns the pre-update value.

Decomposition:
- Shared package perf_pkg:
  - Event index enum (EV_CYCLE, EV_STALL, EV_BUBBLE, EV_L1I_HIT, EV_L1I_MISS, EV_L1D_HIT, EV_L1D_MISS, EV_L2_HIT, EV_L2_MISS, EV_BR, EV_BR_CORR, EV_BTB_MISS, ...).
  - Localparam NUM_EV.
  - Typedefs for the read-source selector and the counter word.
- Sub-module perf_counter_cell: one channel covering adder, wrap/saturate, ovf flag, clear and snapshot register.
  - Instantiated NUM_CNT times in a generate loop.
  - The read mux and response register stay in perf_counter_bank.

Test Plan:
1. Reset then en_i=1, inc=1 on ch0 for 10 cycles; rd_req sel=0 src=0 -> one cycle later rd_valid_o=1, rd_data_o=10, rd_err_o=0.
2. CNT_W=8, SAT_MODE=0: ch3 at 254, inc=3 -> ch3=1, ovf_o[3]=1. Same stimulus with SAT_MODE=1 -> ch3=255, ovf_o[3]=1; a further inc=1 keeps 255.
3. ch1=100, inc=2, snap_i and clear_i in the same cycle -> snapshot ch1=102, live ch1=0, snap_valid_o=1; read src=1 sel=1 returns 102.
4. en_i=0 with inc=3 on all channels for 5 cycles -> all counters unchanged. clear_i with inc active -> counters 0 and ovf_o all 0.
5. NUM_CNT=24: rd_req with sel=30 -> rd_valid_o=1, rd_data_o=0, rd_err_o=1. rd_req held for sel 0,1,2 on consecutive cycles -> three consecutive valid responses with matching data.
6. Assert rst mid-count with a read in flight -> all outputs 0 asynchronously. After release, counting restarts from 0.
